// File: rtl/histogram_reduce_if.sv
// Block-level bundle for histogram_reduce: ap_ctrl_chain handshake, the two
// partial-histogram read ports, the merged-histogram write port and the total.
// The block itself connects through the slave modport; the environment that
// drives start/continue and owns the BRAMs uses the master modport.
interface histogram_reduce_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // Block control
  logic              ap_start;
  logic              ap_done;
  logic              ap_continue;
  logic              ap_idle;
  logic              ap_ready;

  // Partial histogram A read port
  logic [ADDR_W-1:0] hist_a_address0;
  logic              hist_a_ce0;
  logic [DATA_W-1:0] hist_a_q0;

  // Partial histogram B read port
  logic [ADDR_W-1:0] hist_b_address0;
  logic              hist_b_ce0;
  logic [DATA_W-1:0] hist_b_q0;

  // Merged histogram write port
  logic [ADDR_W-1:0] hist_out_address0;
  logic              hist_out_ce0;
  logic              hist_out_we0;
  logic [DATA_W-1:0] hist_out_d0;

  // Sum of all merged bins of the last completed run
  logic [DATA_W-1:0] total_count;

  modport slave (
    input  ap_start, ap_continue, hist_a_q0, hist_b_q0,
    output ap_done, ap_idle, ap_ready,
           hist_a_address0, hist_a_ce0,
           hist_b_address0, hist_b_ce0,
           hist_out_address0, hist_out_ce0, hist_out_we0, hist_out_d0,
           total_count
  );

  modport master (
    output ap_start, ap_continue, hist_a_q0, hist_b_q0,
    input  ap_done, ap_idle, ap_ready,
           hist_a_address0, hist_a_ce0,
           hist_b_address0, hist_b_ce0,
           hist_out_address0, hist_out_ce0, hist_out_we0, hist_out_d0,
           total_count
  );
endinterface

// File: rtl/histogram_reduce.sv
// histogram_reduce: merges two partial histograms bin by bin (out = a + b,
// modulo 2^DATA_W) into an output BRAM and reports the grand total of the
// merged bins. Reads are issued one bin per cycle; each read result comes
// back one cycle later and is written out immediately, so the write stream
// trails the read stream by exactly one cycle and finishes in DRAIN.
module histogram_reduce #(
  parameter int N_BINS = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  histogram_reduce_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_RUN   = 3'b010,
    S_DRAIN = 3'b100
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BINS - 1);

  state_t            state;
  logic [ADDR_W-1:0] rd_idx;        // bin being read this cycle
  logic [ADDR_W-1:0] wr_idx;        // bin whose read data arrives this cycle
  logic              wr_vld;        // read data on q0 is valid, write it out
  logic [DATA_W-1:0] acc;           // running sum of bins written so far
  logic [DATA_W-1:0] total_count_r;
  logic              ap_done_reg;
  logic [DATA_W-1:0] merged;

  // Merged bin value straight from the BRAM outputs; wraps silently.
  assign merged = bus.hist_a_q0 + bus.hist_b_q0;

  // Read side: both partial histograms are read in lockstep during RUN only.
  assign bus.hist_a_address0 = rd_idx;
  assign bus.hist_b_address0 = rd_idx;
  assign bus.hist_a_ce0      = (state == S_RUN);
  assign bus.hist_b_ce0      = (state == S_RUN);

  // Write side: one write per cycle whenever returning read data is valid.
  assign bus.hist_out_address0 = wr_idx;
  assign bus.hist_out_ce0      = wr_vld;
  assign bus.hist_out_we0      = wr_vld;
  assign bus.hist_out_d0       = merged;

  // Block handshake: done/ready pulse combinationally in DRAIN, done is then
  // held until the downstream stage acknowledges with ap_continue.
  assign bus.ap_ready    = (state == S_DRAIN);
  assign bus.ap_done     = (state == S_DRAIN) || ap_done_reg;
  assign bus.ap_idle     = (state == S_IDLE) && !bus.ap_start;
  assign bus.total_count = total_count_r;

  // Control FSM plus read/write index pipeline, accumulator and done latch.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state         <= S_IDLE;
      rd_idx        <= '0;
      wr_idx        <= '0;
      wr_vld        <= 1'b0;
      acc           <= '0;
      total_count_r <= '0;
      ap_done_reg   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; where two assign the same register in
      // one cycle the later one wins, which the start-accept clear of acc relies on
      // never colliding with (wr_vld is always 0 in IDLE).
      if (wr_vld) begin
        acc <= acc + merged;
      end

      unique case (state)
        S_IDLE: begin
          if (bus.ap_start && !ap_done_reg) begin
            rd_idx <= '0;
            acc    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          rd_idx <= rd_idx + 1'b1;
          wr_idx <= rd_idx;
          wr_vld <= 1'b1;
          if (rd_idx == LAST_IDX) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          total_count_r <= acc + merged;
          wr_vld        <= 1'b0;
          state         <= S_IDLE;
        end
        default: begin
          wr_vld <= 1'b0;
          state  <= S_IDLE;
        end
      endcase

      // Acknowledge beats a new completion arriving in the same cycle.
      if (bus.ap_continue) begin
        ap_done_reg <= 1'b0;
      end else if (state == S_DRAIN) begin
        ap_done_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_histogram_reduce.sv
// Self-checking bench for histogram_reduce. BRAMs are modelled as arrays with
// one-cycle read latency. Expected merged bins and totals are computed from
// the array contents and queued when a run is launched; a monitor on the
// falling edge pops and compares every write and every new total_count.
module tb_histogram_reduce;

  localparam int N_BINS = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   cyc      = 0;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  histogram_reduce_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  histogram_reduce #(.N_BINS(N_BINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  logic [DATA_W-1:0] mem_a   [N_BINS];
  logic [DATA_W-1:0] mem_b   [N_BINS];
  logic [DATA_W-1:0] out_mem [N_BINS];

  wr_t               exp_wr  [$];
  logic [DATA_W-1:0] exp_tot [$];

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;
  int rd_expect   = 0;

  // BRAM models: registered read, write on ce&we.
  always @(posedge ap_clk) begin
    if (bus.hist_a_ce0) bus.hist_a_q0 <= mem_a[bus.hist_a_address0];
    if (bus.hist_b_ce0) bus.hist_b_q0 <= mem_b[bus.hist_b_address0];
    if (bus.hist_out_ce0 && bus.hist_out_we0) out_mem[bus.hist_out_address0] <= bus.hist_out_d0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: merged bin = a + b mod 2^DATA_W, total = sum of merged.
  function automatic void push_expected();
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] tot;
    tot = '0;
    for (int i = 0; i < N_BINS; i++) begin
      s   = mem_a[i] + mem_b[i];
      tot = tot + s;
      exp_wr.push_back('{addr: ADDR_W'(i), data: s});
    end
    exp_tot.push_back(tot);
  endfunction

  task automatic load_random(input bit full_range);
    for (int i = 0; i < N_BINS; i++) begin
      mem_a[i] = full_range ? $urandom() : $urandom_range(0, 5000);
      mem_b[i] = full_range ? $urandom() : $urandom_range(0, 5000);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Waits (bounded) for ap_done; reports the cycle label at which it was seen.
  task automatic wait_done(output int done_cyc);
    int n;
    n = 0;
    while (!bus.ap_done && n < 2000) begin
      tick();
      n++;
    end
    check("done_within_budget", n < 2000, 1);
    done_cyc = cyc;
  endtask

  // Pushes expectations, pulses ap_start for one cycle; t0 is the accept cycle.
  task automatic launch(input logic cont, output int t0);
    push_expected();
    ap_continue = cont;
    bus.ap_start = 1'b1;
    t0 = cyc;
    tick();
    bus.ap_start = 1'b0;
  endtask

  task automatic run_checked(input logic cont, input string name);
    int t0;
    int dc;
    launch(cont, t0);
    wait_done(dc);
    check({name, "_done_latency"}, dc - t0, N_BINS + 1);
  endtask

  logic ap_continue;
  assign bus.ap_continue = ap_continue;

  // Monitor: checks reads in order, every write against the scoreboard, and
  // total_count the cycle after each DRAIN.
  initial begin : monitor
    bit  tot_pending;
    wr_t w;
    tot_pending = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        tot_pending = 1'b0;
      end else begin
        if (tot_pending) begin
          tot_pending = 1'b0;
          check("total_expected", exp_tot.size() != 0, 1);
          if (exp_tot.size() != 0) check("total_count", bus.total_count, exp_tot.pop_front());
        end
        if (bus.hist_a_ce0 || bus.hist_b_ce0) begin
          check("read_ce_pair", {bus.hist_a_ce0, bus.hist_b_ce0}, 2'b11);
          check("read_addr_a", bus.hist_a_address0, rd_expect);
          check("read_addr_b", bus.hist_b_address0, rd_expect);
          rd_expect = (rd_expect + 1) % N_BINS;
        end
        if (bus.hist_out_ce0 || bus.hist_out_we0) begin
          wr_count++;
          check("write_expected", exp_wr.size() != 0, 1);
          check("write_we_with_ce", {bus.hist_out_ce0, bus.hist_out_we0}, 2'b11);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            check("write_addr", bus.hist_out_address0, w.addr);
            check("write_data", bus.hist_out_d0, w.data);
          end
        end
        if (bus.ap_ready) tot_pending = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : driver
    int t0;
    int d1;
    int d2;
    int dc;
    int bad;
    int first_rd;
    int n;
    bit idle_seen;
    bit found;

    bus.ap_start = 1'b0;
    ap_continue  = 1'b0;
    for (int i = 0; i < N_BINS; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    ap_rst_n = 1'b0;
    repeat (3) tick();
    ap_rst_n = 1'b1;

    // Reset state and idle behaviour.
    check("reset_total_count", bus.total_count, 0);
    check("reset_done", bus.ap_done, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ap_idle !== 1'b1 || bus.ap_ready !== 1'b0 || bus.ap_done !== 1'b0 ||
          bus.hist_a_ce0 !== 1'b0 || bus.hist_b_ce0 !== 1'b0 ||
          bus.hist_out_ce0 !== 1'b0 || bus.hist_out_we0 !== 1'b0) bad++;
    end
    check("idle_20_cycles_bad", bad, 0);

    // Distinct patterns a=i, b=2i.
    for (int i = 0; i < N_BINS; i++) begin
      mem_a[i] = DATA_W'(i);
      mem_b[i] = DATA_W'(2 * i);
    end
    wr_count = 0;
    launch(1'b1, t0);
    wait_done(dc);
    check("pattern_done_latency", dc - t0, N_BINS + 1);
    check("pattern_ready_in_drain", bus.ap_ready, 1);
    tick();
    check("pattern_done_one_cycle", bus.ap_done, 0);
    tick();
    check("pattern_total_97920", bus.total_count, 97920);
    check("pattern_write_count", wr_count, N_BINS);
    bad = 0;
    for (int i = 0; i < N_BINS; i++) if (out_mem[i] !== DATA_W'(3 * i)) bad++;
    check("pattern_out_bins_bad", bad, 0);

    // Wrap-around of a single bin.
    for (int i = 0; i < N_BINS; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[5] = 32'hFFFF_FFFF;
    mem_b[5] = 32'd2;
    run_checked(1'b1, "wrap");
    repeat (2) tick();
    check("wrap_out5", out_mem[5], 1);
    check("wrap_total", bus.total_count, 1);

    // Done hold with ap_continue low, start ignored, then release.
    load_random(1'b0);
    run_checked(1'b0, "hold");
    load_random(1'b1);
    push_expected();
    bus.ap_start = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ap_done !== 1'b1) bad++;
      if (bus.hist_a_ce0 || bus.hist_b_ce0 || bus.hist_out_ce0) bad++;
    end
    check("hold_done_and_no_ce_bad", bad, 0);
    ap_continue = 1'b1;
    tick();
    check("hold_done_cleared", bus.ap_done, 0);
    t0 = cyc;
    tick();
    check("hold_run_starts", bus.hist_a_ce0, 1);
    bus.ap_start = 1'b0;
    wait_done(dc);
    check("hold_release_latency", dc - t0, N_BINS + 1);

    // Back-to-back runs with start and continue held high.
    tick();
    load_random(1'b1);
    push_expected();
    ap_continue  = 1'b1;
    bus.ap_start = 1'b1;
    wait_done(d1);
    load_random(1'b0);
    push_expected();
    idle_seen = 1'b0;
    first_rd  = -1;
    n = 0;
    do begin
      tick();
      n++;
      if (bus.ap_idle) idle_seen = 1'b1;
      if (bus.hist_a_ce0 && first_rd < 0) first_rd = cyc;
    end while (!bus.ap_ready && n < 2000);
    d2 = cyc;
    bus.ap_start = 1'b0;
    check("b2b_done_interval", d2 - d1, N_BINS + 2);
    check("b2b_second_read_start", first_rd - d1, 2);
    check("b2b_idle_never", idle_seen, 0);
    repeat (2) tick();

    // Reset in the middle of a run.
    load_random(1'b1);
    launch(1'b1, t0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.hist_a_ce0 && bus.hist_a_address0 == ADDR_W'(100)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reset_reached_k100", found, 1);
    ap_rst_n = 1'b0;
    tick();
    check("midrst_ce_we", {bus.hist_a_ce0, bus.hist_b_ce0, bus.hist_out_ce0, bus.hist_out_we0}, 4'b0000);
    check("midrst_done", bus.ap_done, 0);
    check("midrst_total", bus.total_count, 0);
    check("midrst_idle", bus.ap_idle, 1);
    exp_wr.delete();
    exp_tot.delete();
    rd_expect = 0;
    ap_rst_n = 1'b1;
    tick();
    load_random(1'b0);
    run_checked(1'b1, "after_reset");
    tick();

    // Further random runs, full-range values to exercise wrap.
    for (int r = 0; r < 3; r++) begin
      load_random(r != 1);
      run_checked(1'b1, "random");
      tick();
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_wr.size() + exp_tot.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
